// File: rtl/map_pkg.sv
// Shared constants for the map loader: ROM layout, point-byte fields and FSM states.
package map_pkg;

  localparam int NUM_ROWS = 8;

  localparam logic [3:0] ADDR_START = 4'd8;
  localparam logic [3:0] ADDR_END   = 4'd9;

  // Point byte = {2 reserved, row[2:0], col[2:0]}
  localparam int PT_COL_LSB = 0;
  localparam int PT_COL_MSB = 2;
  localparam int PT_ROW_LSB = 3;
  localparam int PT_ROW_MSB = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/map_loader.sv
// Loads an 8x8 maze bitmap plus start/end points from an external ROM.
// Optional MAP_LOADER_VALIDATE_EN adds map_err when the start or end cell is closed.
module map_loader
  import map_pkg::*;
#(
  parameter int ROM_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] map_sel,
  output logic       busy,
  output logic       done,
  output logic [1:0] rom_chipsel,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [2:0] q_row,
  input  logic [2:0] q_col,
  output logic       q_open,
  output logic [2:0] start_row,
  output logic [2:0] start_col,
  output logic [2:0] end_row,
  output logic [2:0] end_col,
  output logic       map_valid
`ifdef MAP_LOADER_VALIDATE_EN
  ,
  output logic       map_err
`endif
);

  state_t             state;
  logic [ROM_LAT-1:0] vld_p;
  logic [3:0]         addr_p [ROM_LAT];
  logic [7:0]         bitmap [NUM_ROWS];
  logic               cap_vld;
  logic [3:0]         cap_addr;

  assign cap_vld  = vld_p[ROM_LAT-1];
  assign cap_addr = addr_p[ROM_LAT-1];
  assign q_open   = bitmap[q_row][q_col];

`ifdef MAP_LOADER_VALIDATE_EN
  logic pts_open;
  assign pts_open = bitmap[start_row][start_col] & bitmap[end_row][end_col];
`endif

  // Address tag pipeline: matches each returning byte to the address issued ROM_LAT cycles earlier
  always_ff @(posedge clk) begin
    addr_p[0] <= rom_addr;
    for (int i = 1; i < ROM_LAT; i++) addr_p[i] <= addr_p[i-1];
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= (state == ST_ISSUE);
      for (int i = 1; i < ROM_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Capture stage: returning byte lands in a row or a point register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_ROWS; r++) bitmap[r] <= '0;
      start_row <= '0;
      start_col <= '0;
      end_row   <= '0;
      end_col   <= '0;
    end else if (cap_vld) begin
      if (cap_addr < ADDR_START) begin
        bitmap[cap_addr[2:0]] <= rom_data;
      end else if (cap_addr == ADDR_START) begin
        start_row <= rom_data[PT_ROW_MSB:PT_ROW_LSB];
        start_col <= rom_data[PT_COL_MSB:PT_COL_LSB];
      end else if (cap_addr == ADDR_END) begin
        end_row <= rom_data[PT_ROW_MSB:PT_ROW_LSB];
        end_col <= rom_data[PT_COL_MSB:PT_COL_LSB];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      map_valid   <= 1'b0;
      rom_addr    <= '0;
      rom_chipsel <= '0;
`ifdef MAP_LOADER_VALIDATE_EN
      map_err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load && (map_sel != 2'd3)) begin
            rom_chipsel <= map_sel;
            rom_addr    <= '0;
            map_valid   <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_ISSUE;
`ifdef MAP_LOADER_VALIDATE_EN
            map_err     <= 1'b0;
`endif
          end
        end
        ST_ISSUE: begin
          if (rom_addr == ADDR_END) begin
            rom_addr <= '0;
            state    <= ST_DRAIN;
          end else begin
            rom_addr <= rom_addr + 4'd1;
          end
        end
        ST_DRAIN: begin
          if (cap_vld && (cap_addr == ADDR_END)) state <= ST_DONE;
        end
        default: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
`ifdef MAP_LOADER_VALIDATE_EN
          map_valid <= pts_open;
          map_err   <= ~pts_open;
`else
          map_valid <= 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_map_loader.sv
// Self-checking bench for map_loader: 2-cycle-latency ROM model, directed and random map loads.
module tb_map_loader;

  logic       clk = 1'b0;
  logic       rst, load;
  logic [1:0] map_sel;
  logic       busy, done, q_open, map_valid;
  logic [1:0] rom_chipsel;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [2:0] q_row, q_col, start_row, start_col, end_row, end_col;
`ifdef MAP_LOADER_VALIDATE_EN
  logic       map_err;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] rom_mem [3][10];
  logic [7:0] exp_rows [8];

  always #5 clk = ~clk;

  map_loader #(.ROM_LAT(2)) dut (
    .clk(clk), .rst(rst), .load(load), .map_sel(map_sel),
    .busy(busy), .done(done), .rom_chipsel(rom_chipsel), .rom_addr(rom_addr),
    .rom_data(rom_data), .q_row(q_row), .q_col(q_col), .q_open(q_open),
    .start_row(start_row), .start_col(start_col), .end_row(end_row), .end_col(end_col),
    .map_valid(map_valid)
`ifdef MAP_LOADER_VALIDATE_EN
    , .map_err(map_err)
`endif
  );

  // ROM model: data for an address appears two cycles after it is driven
  logic [1:0] sel_d1, sel_d2;
  logic [3:0] addr_d1, addr_d2;
  always @(posedge clk) begin
    sel_d1  <= rom_chipsel;
    addr_d1 <= rom_addr;
    sel_d2  <= sel_d1;
    addr_d2 <= addr_d1;
  end
  always_comb begin
    rom_data = 8'h00;
    if (sel_d2 != 2'd3 && addr_d2 < 4'd10) rom_data = rom_mem[sel_d2][addr_d2];
  end

  function automatic bit exp_ok(input int sel);
    logic [7:0] s, e;
    s = rom_mem[sel][8];
    e = rom_mem[sel][9];
    return rom_mem[sel][s[5:3]][s[2:0]] && rom_mem[sel][e[5:3]][e[2:0]];
  endfunction

  function automatic bit exp_map_valid(input int sel);
`ifdef MAP_LOADER_VALIDATE_EN
    return exp_ok(sel);
`else
    return (sel >= 0);
`endif
  endfunction

  task automatic fill_rows(input int sel);
    for (int r = 0; r < 8; r++) exp_rows[r] = rom_mem[sel][r];
  endtask

  // Counts bitmap cells whose q_open differs from exp_rows
  task automatic scan(output int bad);
    bad = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        q_row = r[2:0];
        q_col = c[2:0];
        #1;
        if (q_open !== exp_rows[r][c]) bad++;
      end
  endtask

  task automatic start_load(input logic [1:0] sel);
    @(negedge clk);
    load    = 1'b1;
    map_sel = sel;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic check_points(input int sel, input string tag);
    logic [7:0] s, e;
    s = rom_mem[sel][8];
    e = rom_mem[sel][9];
    total_cnt++;
    if ({start_row, start_col, end_row, end_col} !== {s[5:0], e[5:0]})
      $display("FAIL %s points: got %0d,%0d/%0d,%0d expected %0d,%0d/%0d,%0d", tag,
               start_row, start_col, end_row, end_col, s[5:3], s[2:0], e[5:3], e[2:0]);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    int bad;
    rst = 1'b1;
    load = 1'b1;
    map_sel = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, map_valid} !== 3'b000)
      $display("FAIL reset_ctrl: got busy/done/valid=%b expected 000", {busy, done, map_valid});
    else pass_cnt++;
    total_cnt++;
    if ({rom_addr, rom_chipsel} !== 6'd0)
      $display("FAIL reset_rom: got addr=%0d sel=%0d expected 0/0", rom_addr, rom_chipsel);
    else pass_cnt++;
    total_cnt++;
    if ({start_row, start_col, end_row, end_col} !== 12'd0)
      $display("FAIL reset_points: got %h expected 0", {start_row, start_col, end_row, end_col});
    else pass_cnt++;
    rst = 1'b0;
    load = 1'b0;
    for (int r = 0; r < 8; r++) exp_rows[r] = 8'h00;
    scan(bad);
    total_cnt++;
    if (bad !== 0) $display("FAIL reset_bitmap: got %0d bad cells expected 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_full_map;
    int n, bad_addr, bad_sel, bad;
    logic [3:0] seen [10];
    for (int r = 0; r < 8; r++) rom_mem[1][r] = 8'hFF;
    rom_mem[1][8] = 8'h00;
    rom_mem[1][9] = 8'h3F;
    start_load(2'd1);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL full_busy: got %b expected 1", busy);
    else pass_cnt++;
    n = 0;
    bad_sel = 0;
    while (n < 40) begin
      if (n < 10) seen[n] = rom_addr;
      if (rom_chipsel !== 2'd1) bad_sel++;
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) break;
    end
    total_cnt++;
    if (n !== 13) $display("FAIL full_latency: got %0d cycles expected 13", n);
    else pass_cnt++;
    bad_addr = 0;
    for (int k = 0; k < 10; k++) if (seen[k] !== k[3:0]) bad_addr++;
    total_cnt++;
    if (bad_addr !== 0 || bad_sel !== 0)
      $display("FAIL full_addr_seq: got %0d bad addrs %0d bad chipsel expected 0/0", bad_addr, bad_sel);
    else pass_cnt++;
    total_cnt++;
    if ({busy, map_valid} !== 2'b01)
      $display("FAIL full_status: got busy/valid=%b expected 01", {busy, map_valid});
    else pass_cnt++;
    check_points(1, "full");
    @(posedge clk);
    #1;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL full_done_pulse: got %b expected 0", done);
    else pass_cnt++;
    fill_rows(1);
    scan(bad);
    total_cnt++;
    if (bad !== 0) $display("FAIL full_bitmap: got %0d bad cells expected 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_bad_sel;
    logic       mv;
    logic [1:0] cs;
    int bad;
    mv = map_valid;
    cs = rom_chipsel;
    start_load(2'd3);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy !== 1'b0 || done !== 1'b0 || rom_addr !== 4'd0 || rom_chipsel !== cs || map_valid !== mv)
        bad++;
      @(posedge clk);
      #1;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL bad_sel_ignored: got %0d disturbed cycles expected 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_row_pattern;
    int n;
    logic [2:0] vals;
    for (int a = 0; a < 10; a++) rom_mem[0][a] = 8'($urandom);
    rom_mem[0][3] = 8'h05;
    start_load(2'd0);
    wait_done(n);
    total_cnt++;
    if (n !== 13) $display("FAIL row_latency: got %0d expected 13", n);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      q_row = 3'd3;
      q_col = c[2:0];
      #1;
      vals[c] = q_open;
    end
    total_cnt++;
    if (vals !== 3'b101) $display("FAIL row_query: got %b expected 101 (cols 2..0)", vals);
    else pass_cnt++;
    check_points(0, "row");
  endtask

  task automatic test_load_while_busy;
    int ndone, done_at, bad_sel, bad;
    for (int a = 0; a < 10; a++) rom_mem[2][a] = 8'($urandom);
    start_load(2'd1);
    ndone = 0;
    done_at = -1;
    bad_sel = 0;
    for (int n = 0; n < 30; n++) begin
      if (n == 3) begin
        load = 1'b1;
        map_sel = 2'd2;
      end
      if (n == 4) load = 1'b0;
      if (rom_chipsel !== 2'd1) bad_sel++;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        done_at = n + 1;
      end
    end
    total_cnt++;
    if (ndone !== 1 || done_at !== 13)
      $display("FAIL busy_ignore_done: got %0d pulses at %0d expected 1 at 13", ndone, done_at);
    else pass_cnt++;
    total_cnt++;
    if (bad_sel !== 0) $display("FAIL busy_ignore_sel: got %0d cycles off chipsel 1 expected 0", bad_sel);
    else pass_cnt++;
    fill_rows(1);
    scan(bad);
    total_cnt++;
    if (bad !== 0) $display("FAIL busy_ignore_map: got %0d bad cells expected 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_midload;
    int bad, ndone, nbusy;
    for (int a = 0; a < 10; a++) rom_mem[0][a] = 8'($urandom) | 8'h01;
    start_load(2'd0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total_cnt++;
    if ({busy, map_valid, done} !== 3'b000)
      $display("FAIL midrst_status: got busy/valid/done=%b expected 000", {busy, map_valid, done});
    else pass_cnt++;
    total_cnt++;
    if ({start_row, start_col, end_row, end_col} !== 12'd0 || rom_addr !== 4'd0)
      $display("FAIL midrst_points: got %h addr %0d expected 0/0", {start_row, start_col, end_row, end_col}, rom_addr);
    else pass_cnt++;
    for (int r = 0; r < 8; r++) exp_rows[r] = 8'h00;
    scan(bad);
    total_cnt++;
    if (bad !== 0) $display("FAIL midrst_bitmap: got %0d bad cells expected 0", bad);
    else pass_cnt++;
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) ndone++;
      if (busy !== 1'b0) nbusy++;
    end
    scan(bad);
    total_cnt++;
    if (ndone !== 0 || nbusy !== 0 || bad !== 0)
      $display("FAIL midrst_quiet: got %0d done %0d busy %0d cells expected 0/0/0", ndone, nbusy, bad);
    else pass_cnt++;
  endtask

  task automatic test_random;
    int n, bad, sel;
    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(0, 2);
      for (int a = 0; a < 10; a++) rom_mem[sel][a] = 8'($urandom);
      start_load(2'(sel));
      wait_done(n);
      total_cnt++;
      if (n !== 13) $display("FAIL rand%0d_latency: got %0d expected 13", it, n);
      else pass_cnt++;
      total_cnt++;
      if (map_valid !== exp_map_valid(sel))
        $display("FAIL rand%0d_valid: got %b expected %b", it, map_valid, exp_map_valid(sel));
      else pass_cnt++;
`ifdef MAP_LOADER_VALIDATE_EN
      total_cnt++;
      if (map_err !== !exp_ok(sel))
        $display("FAIL rand%0d_err: got %b expected %b", it, map_err, !exp_ok(sel));
      else pass_cnt++;
`endif
      check_points(sel, "rand");
      fill_rows(sel);
      scan(bad);
      total_cnt++;
      if (bad !== 0) $display("FAIL rand%0d_bitmap: got %0d bad cells expected 0", it, bad);
      else pass_cnt++;
    end
  endtask

`ifdef MAP_LOADER_VALIDATE_EN
  task automatic test_validate;
    int n;
    for (int a = 0; a < 10; a++) rom_mem[0][a] = 8'($urandom);
    rom_mem[0][1] = 8'h00;
    rom_mem[0][8] = 8'h09;
    start_load(2'd0);
    wait_done(n);
    total_cnt++;
    if ({done, map_err, map_valid} !== 3'b110)
      $display("FAIL validate_err: got done/err/valid=%b expected 110", {done, map_err, map_valid});
    else pass_cnt++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    load = 1'b0;
    map_sel = 2'd0;
    q_row = 3'd0;
    q_col = 3'd0;
    for (int s = 0; s < 3; s++)
      for (int a = 0; a < 10; a++) rom_mem[s][a] = 8'h00;
    test_reset;
    test_full_map;
    test_bad_sel;
    test_row_pattern;
    test_load_while_busy;
    test_reset_midload;
    test_random;
`ifdef MAP_LOADER_VALIDATE_EN
    test_validate;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
